uart_tx_sched: RTL



---
 rtl/uart_sched_pkg.sv | 22 ++
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_tx_sched_rr_pick.sv | 28 ++
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int BYTE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LAUNCH = 2'd1;
  localparam state_t SEND   = 2'd2;

  // Ceiling log2 with a floor of one bit, used to size counters.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and uart_tx handshake bundle for the transmit scheduler.
interface uart_tx_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_done;
  logic [7:0]        uart_txdata;
  logic              uart_txbegin;
  logic              uart_txbusy;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              launch_err;

  modport slave (
    input  req_valid, req_data, uart_txbusy,
    output req_ready, req_done, uart_txdata, uart_txbegin, busy, grant_id, launch_err
  );

  modport master (
    output req_valid, req_data, uart_txbusy,
    input  req_ready, req_done, uart_txdata, uart_txbegin, busy, grant_id, launch_err
  );

endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  winner
);

  logic [2*NREQ-1:0] dbl_s;
  logic [2*NREQ-1:0] rot_s;

  assign dbl_s = {req, req};
  assign rot_s = dbl_s >> ptr;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      found  = rot_s[k] ? 1'b1 : found;
      winner = rot_s[k] ? IDW'((int'(ptr) + k) % NREQ) : winner;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NREQ single-byte holding slots.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int LAUNCH_TIMEOUT = 1024,
  parameter int IDW            = 3
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_sched_if.slave bus
);

  localparam int               CNT_W    = clog2(LAUNCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);

  state_t            state_r;
  logic [NREQ-1:0]   slot_full_r;
  logic [BYTE_W-1:0] slot_data_r [NREQ];
  logic [IDW-1:0]    rr_ptr_r;
  logic [IDW-1:0]    grant_id_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [NREQ-1:0]   req_done_r;
  logic [BYTE_W-1:0] txdata_r;
  logic              txbegin_r;
  logic              launch_err_r;

  logic              found_s;
  logic              grant_s;
  logic [IDW-1:0]    win_s;
  logic [BYTE_W-1:0] win_data_s;
  logic [NREQ-1:0]   gid_onehot_s;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (slot_full_r),
    .ptr    (rr_ptr_r),
    .found  (found_s),
    .winner (win_s)
  );

  assign grant_s = (state_r == IDLE) & found_s;

  // Select the winning slot's byte and decode the current owner to one-hot.
  always_comb begin
    win_data_s   = '0;
    gid_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_data_s      = (win_s == IDW'(i)) ? slot_data_r[i] : win_data_s;
      gid_onehot_s[i] = (grant_id_r == IDW'(i));
    end
  end

  // Holding slots: a grant empties a slot, an accepted offer fills an empty one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full_r <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_s && (win_s == IDW'(i))) begin
          slot_full_r[i] <= 1'b0;
        end else if (bus.req_valid[i] && !slot_full_r[i]) begin
          slot_full_r[i] <= 1'b1;
          slot_data_r[i] <= bus.req_data[BYTE_W*i +: BYTE_W];
        end
      end
    end
  end

  // Scheduler FSM, launch timeout and registered uart_tx controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      grant_id_r   <= '0;
      cnt_r        <= '0;
      txdata_r     <= '0;
      txbegin_r    <= 1'b0;
      req_done_r   <= '0;
      launch_err_r <= 1'b0;
    end else begin
      req_done_r   <= '0;
      launch_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            txdata_r   <= win_data_s;
            grant_id_r <= win_s;
            rr_ptr_r   <= (win_s == IDW'(NREQ - 1)) ? '0 : (win_s + IDW'(1));
            txbegin_r  <= 1'b1;
            cnt_r      <= '0;
            state_r    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (bus.uart_txbusy) begin
            txbegin_r <= 1'b0;
            state_r   <= SEND;
          end else if (cnt_r == CNT_LAST) begin
            // uart_tx never acknowledged: drop the byte without a done pulse
            txbegin_r    <= 1'b0;
            launch_err_r <= 1'b1;
            state_r      <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        SEND: begin
          if (!bus.uart_txbusy) begin
            req_done_r <= gid_onehot_s;
            state_r    <= IDLE;
          end
        end
        default: begin
          txbegin_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ~slot_full_r;
  assign bus.req_done     = req_done_r;
  assign bus.uart_txdata  = txdata_r;
  assign bus.uart_txbegin = txbegin_r;
  assign bus.grant_id     = grant_id_r;
  assign bus.launch_err   = launch_err_r;
  assign bus.busy         = (state_r != IDLE) | (|slot_full_r);

endmodule
